// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one combinational 16-bit Shifter between two requesters.
// Optional SHIFT_ARB_ZERO_BYPASS_EN: val==0 legal requests skip the Shifter and respond one cycle early.
module shift_arbiter #(
   parameter int DATA_W = 16,
   parameter int VAL_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        req_valid,
   output logic [1:0]        req_ready,
   input  logic [DATA_W-1:0] req0_data,
   input  logic [VAL_W-1:0]  req0_val,
   input  logic [1:0]        req0_mode,
   input  logic [DATA_W-1:0] req1_data,
   input  logic [VAL_W-1:0]  req1_val,
   input  logic [1:0]        req1_mode,
   output logic [1:0]        rsp_valid,
   input  logic [1:0]        rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_err,
   output logic [DATA_W-1:0] shift_in,
   output logic [VAL_W-1:0]  shift_val,
   output logic [1:0]        shift_mode,
   input  logic [DATA_W-1:0] shift_out
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

   state_t            r_state;
   logic              r_rr_ptr;
   logic              r_gid;
   logic [1:0]        r_rsp_valid;
   logic [DATA_W-1:0] r_rsp_data;
   logic              r_rsp_err;
   logic [DATA_W-1:0] r_shift_in;
   logic [VAL_W-1:0]  r_shift_val;
   logic [1:0]        r_shift_mode;

   logic              w_gnt_vld;
   logic              w_gnt_id;
   logic              w_bypass;
   logic [DATA_W-1:0] w_sel_data;
   logic [VAL_W-1:0]  w_sel_val;
   logic [1:0]        w_sel_mode;

   // A lone requester wins outright; a tie goes to the round-robin pointer.
   assign w_gnt_vld  = (r_state == S_IDLE) && (|req_valid) && !rst;
   assign w_gnt_id   = (req_valid == 2'b11) ? r_rr_ptr : req_valid[1];
   assign req_ready  = w_gnt_vld ? {w_gnt_id, ~w_gnt_id} : 2'b00;

   assign w_sel_data = w_gnt_id ? req1_data : req0_data;
   assign w_sel_val  = w_gnt_id ? req1_val  : req0_val;
   assign w_sel_mode = w_gnt_id ? req1_mode : req0_mode;

`ifdef SHIFT_ARB_ZERO_BYPASS_EN
   assign w_bypass = (w_sel_val == '0) && (w_sel_mode != 2'b11);
`else
   assign w_bypass = 1'b0;
`endif

   assign rsp_valid  = r_rsp_valid;
   assign rsp_data   = r_rsp_data;
   assign rsp_err    = r_rsp_err;
   assign shift_in   = r_shift_in;
   assign shift_val  = r_shift_val;
   assign shift_mode = r_shift_mode;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_rr_ptr     <= 1'b0;
         r_gid        <= 1'b0;
         r_rsp_valid  <= 2'b00;
         r_rsp_data   <= '0;
         r_rsp_err    <= 1'b0;
         r_shift_in   <= '0;
         r_shift_val  <= '0;
         r_shift_mode <= 2'b00;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_gnt_vld) begin
                  r_gid    <= w_gnt_id;
                  r_rr_ptr <= ~w_gnt_id;
                  if (w_bypass) begin
                     r_rsp_data  <= w_sel_data;
                     r_rsp_err   <= 1'b0;
                     r_rsp_valid <= {w_gnt_id, ~w_gnt_id};
                     r_state     <= S_RESP;
                  end else begin
                     // Shifter registers double as the latched operands.
                     r_shift_in   <= w_sel_data;
                     r_shift_val  <= w_sel_val;
                     r_shift_mode <= w_sel_mode;
                     r_state      <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
               if (r_shift_mode == 2'b11) begin
                  r_rsp_data <= r_shift_in;
                  r_rsp_err  <= 1'b1;
               end else begin
                  r_rsp_data <= shift_out;
                  r_rsp_err  <= 1'b0;
               end
               r_rsp_valid <= {r_gid, ~r_gid};
               r_state     <= S_RESP;
            end
            S_RESP: begin
               if (rsp_ready[r_gid]) begin
                  r_rsp_valid <= 2'b00;
                  r_rsp_err   <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed self-checking bench for shift_arbiter with a behavioural Shifter model.
module tb_shift_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req_valid, req_ready, req0_mode, req1_mode;
   logic [15:0] req0_data, req1_data;
   logic [3:0]  req0_val, req1_val;
   logic [1:0]  rsp_valid, rsp_ready;
   logic [15:0] rsp_data;
   logic        rsp_err;
   logic [15:0] shift_in, shift_out;
   logic [3:0]  shift_val;
   logic [1:0]  shift_mode;
   logic [31:0] rot_tmp;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   shift_arbiter dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req0_data(req0_data), .req0_val(req0_val), .req0_mode(req0_mode),
      .req1_data(req1_data), .req1_val(req1_val), .req1_mode(req1_mode),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_err(rsp_err),
      .shift_in(shift_in), .shift_val(shift_val), .shift_mode(shift_mode),
      .shift_out(shift_out)
   );

   // Shifter model; mode 11 returns a distinct garbage value so ignoring it is observable.
   always_comb begin
      rot_tmp = {shift_in, shift_in} >> shift_val;
      case (shift_mode)
         2'b00:   shift_out = shift_in << shift_val;
         2'b01:   shift_out = shift_in >> shift_val;
         2'b10:   shift_out = rot_tmp[15:0];
         default: shift_out = ~shift_in;
      endcase
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
      req0_data = '0; req0_val = '0; req0_mode = '0;
      req1_data = '0; req1_val = '0; req1_mode = '0;
      tick(); tick();
      rst = 1'b0; #1;
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got %b exp 00", req_ready); end
      checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got %b exp 00", rsp_valid); end
      checks++; if (rsp_data !== 16'h0000 || rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp got %h/%b exp 0000/0", rsp_data, rsp_err); end
      checks++; if (shift_in !== 16'h0 || shift_val !== 4'h0 || shift_mode !== 2'b00) begin errors++; $display("FAIL reset_shift got %h/%h/%b exp 0/0/00", shift_in, shift_val, shift_mode); end
   endtask

   task automatic test_single();
      req0_data = 16'h8001; req0_val = 4'd1; req0_mode = 2'b00;
      req_valid = 2'b01; rsp_ready = 2'b01; #1;
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_req_ready got %b exp 01", req_ready); end
      tick(); req_valid = 2'b00; #1;
      checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL single_issue_valid got %b exp 00", rsp_valid); end
      checks++; if (shift_in !== 16'h8001 || shift_val !== 4'd1 || shift_mode !== 2'b00) begin errors++; $display("FAIL single_shift got %h/%h/%b exp 8001/1/00", shift_in, shift_val, shift_mode); end
      tick();
      checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL single_rsp_valid got %b exp 01", rsp_valid); end
      checks++; if (rsp_data !== 16'h0002 || rsp_err !== 1'b0) begin errors++; $display("FAIL single_rsp got %h/%b exp 0002/0", rsp_data, rsp_err); end
      tick();
      checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL single_rsp_done got %b exp 00", rsp_valid); end
   endtask

   task automatic test_fairness();
      logic [1:0]  exp_rdy;
      logic [15:0] exp_dat;
      rst = 1'b1; tick(); rst = 1'b0;
      req0_data = 16'h00F0; req0_val = 4'd4; req0_mode = 2'b01;
      req1_data = 16'h0001; req1_val = 4'd1; req1_mode = 2'b10;
      req_valid = 2'b11; rsp_ready = 2'b11; #1;
      for (int i = 0; i < 4; i++) begin
         exp_rdy = (i % 2 == 0) ? 2'b01 : 2'b10;
         exp_dat = (i % 2 == 0) ? 16'h000F : 16'h8000;
         checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL fair_grant%0d got %b exp %b", i, req_ready, exp_rdy); end
         tick(); tick();
         checks++; if (rsp_valid !== exp_rdy || rsp_data !== exp_dat) begin errors++; $display("FAIL fair_rsp%0d got %b/%h exp %b/%h", i, rsp_valid, rsp_data, exp_rdy, exp_dat); end
         checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL fair_no_overlap%0d got %b exp 00", i, req_ready); end
         tick();
      end
      req_valid = 2'b00; tick();
   endtask

   task automatic test_illegal();
      req1_data = 16'h1234; req1_val = 4'd3; req1_mode = 2'b11;
      req_valid = 2'b10; rsp_ready = 2'b01; #1;
      checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL illegal_req_ready got %b exp 10", req_ready); end
      tick(); req_valid = 2'b00; tick();
      checks++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL illegal_rsp_valid got %b exp 10", rsp_valid); end
      checks++; if (rsp_data !== 16'h1234 || rsp_err !== 1'b1) begin errors++; $display("FAIL illegal_rsp got %h/%b exp 1234/1", rsp_data, rsp_err); end
      tick();
      checks++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL illegal_wrong_ready got %b exp 10", rsp_valid); end
      rsp_ready = 2'b10; tick();
      checks++; if (rsp_valid !== 2'b00 || rsp_err !== 1'b0) begin errors++; $display("FAIL illegal_done got %b/%b exp 00/0", rsp_valid, rsp_err); end
   endtask

   task automatic test_backpressure();
      req0_data = 16'hABCD; req0_val = 4'd8; req0_mode = 2'b10;
      req_valid = 2'b01; rsp_ready = 2'b00; #1;
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL bp_req_ready got %b exp 01", req_ready); end
      tick(); tick();
      for (int i = 0; i < 5; i++) begin
         checks++; if (rsp_valid !== 2'b01 || rsp_data !== 16'hCDAB || req_ready !== 2'b00) begin errors++; $display("FAIL bp_hold%0d got %b/%h/%b exp 01/cdab/00", i, rsp_valid, rsp_data, req_ready); end
         tick();
      end
      req_valid = 2'b00; rsp_ready = 2'b01; #1;
      checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL bp_last got %b exp 01", rsp_valid); end
      tick();
      checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL bp_release got %b exp 00", rsp_valid); end
      req_valid = 2'b01; #1;
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL bp_idle got %b exp 01", req_ready); end
      req_valid = 2'b00; tick();
   endtask

   task automatic test_reset_mid();
      req0_data = 16'h1111; req0_val = 4'd1; req0_mode = 2'b00;
      req1_data = 16'h4444; req1_val = 4'd2; req1_mode = 2'b00;
      req_valid = 2'b01; rsp_ready = 2'b00;
      tick(); req_valid = 2'b00; tick();
      checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL rstmid_pre got %b exp 01", rsp_valid); end
      rst = 1'b1; tick();
      checks++; if (rsp_valid !== 2'b00 || rsp_data !== 16'h0 || rsp_err !== 1'b0) begin errors++; $display("FAIL rstmid_clear got %b/%h/%b exp 00/0000/0", rsp_valid, rsp_data, rsp_err); end
      checks++; if (shift_in !== 16'h0 || req_ready !== 2'b00) begin errors++; $display("FAIL rstmid_shift got %h/%b exp 0000/00", shift_in, req_ready); end
      rst = 1'b0; req_valid = 2'b11; #1;
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rstmid_ptr got %b exp 01", req_ready); end
      tick(); req_valid = 2'b00; rsp_ready = 2'b11; tick();
      checks++; if (rsp_valid !== 2'b01 || rsp_data !== 16'h2222) begin errors++; $display("FAIL rstmid_after got %b/%h exp 01/2222", rsp_valid, rsp_data); end
      tick();
   endtask

   task automatic test_zero_val();
      req0_data = 16'h5A5A; req0_val = 4'd0; req0_mode = 2'b00;
      req_valid = 2'b01; rsp_ready = 2'b01; #1;
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL zero_req_ready got %b exp 01", req_ready); end
      tick(); req_valid = 2'b00;
`ifdef SHIFT_ARB_ZERO_BYPASS_EN
      checks++; if (rsp_valid !== 2'b01 || rsp_data !== 16'h5A5A) begin errors++; $display("FAIL zero_bypass got %b/%h exp 01/5a5a", rsp_valid, rsp_data); end
      tick();
      checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL zero_done got %b exp 00", rsp_valid); end
`else
      checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL zero_issue got %b exp 00", rsp_valid); end
      tick();
      checks++; if (rsp_valid !== 2'b01 || rsp_data !== 16'h5A5A) begin errors++; $display("FAIL zero_rsp got %b/%h exp 01/5a5a", rsp_valid, rsp_data); end
      tick();
      checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL zero_done got %b exp 00", rsp_valid); end
`endif
   endtask

   initial begin
      test_reset();
      test_single();
      test_fairness();
      test_illegal();
      test_backpressure();
      test_reset_mid();
      test_zero_val();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Round-robin arbiter that shares the single 16-bit Shifter between two requesters (req0 = execute-stage ALU shift ops, req1 = immediate/byte-load formatting path).
- Accepts requests over a valid/ready handshake and registers the operands.
- Drives the Shifter's Shift_In/Shift_Val/Mode from those registers, captures Shift_Out, and returns the result to the granted requester over a valid/ready response channel.
- One transaction in flight at a time.

Parameters:
- DATA_W, 16: operand/result width; must equal the Shifter data width.
- VAL_W, 4: shift-amount width; must equal the Shifter Shift_Val width.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  2  per-requester request valid (bit i = requester i)
- req_ready  output  2  per-requester accept; bit i high only when that request is taken this cycle
- req0_data  input  DATA_W  requester 0 operand
- req0_val  input  VAL_W  requester 0 shift amount
- req0_mode  input  2  requester 0 mode: 00 shift left logical, 01 shift right, 10 rotate right, 11 illegal
- req1_data  input  DATA_W  requester 1 operand
- req1_val  input  VAL_W  requester 1 shift amount
- req1_mode  input  2  requester 1 mode, same encoding
- rsp_valid  output  2  per-requester response valid
- rsp_ready  input  2  per-requester response accept
- rsp_data  output  DATA_W  result, shared by both response channels
- rsp_err  output  1  high with rsp_valid when the mode was 11
- shift_in  output  DATA_W  to Shifter Shift_In
- shift_val  output  VAL_W  to Shifter Shift_Val
- shift_mode  output  2  to Shifter Mode
- shift_out  input  DATA_W  from Shifter Shift_Out (combinational)

Behaviour:
- Reset values: state = IDLE, rr_ptr = 0 (requester 0 has priority), req_ready = 00, rsp_valid = 00, rsp_data = 0, rsp_err = 0, shift_in/shift_val/shift_mode = 0.
- States: IDLE, ISSUE, RESP.
- IDLE:
  - req_ready is combinational. If exactly one requester is valid, grant it. If both are valid, grant requester rr_ptr.
  - On grant: latch data, val, mode and grant id; rr_ptr <= ~granted id; go to ISSUE.
  - No valid requests: stay in IDLE; req_ready = 00.
- ISSUE (one cycle):
  - shift_* outputs driven from the latched operands.
  - End of cycle: rsp_data <= shift_out. If mode == 11, rsp_data <= latched operand unchanged and rsp_err <= 1.
  - Go to RESP.
- RESP:
  - rsp_valid[grant id] = 1; the other bit stays 0. rsp_data and rsp_err held stable.
  - When rsp_ready[grant id] is high, go to IDLE next cycle and clear rsp_err. rsp_ready on the non-granted bit is ignored.
- req_ready = 00 in ISSUE and RESP (no overlap; at most one transaction in flight).
- Latency: accept in cycle N, Shifter driven in N+1, rsp_valid high in N+2. Minimum issue interval is 3 cycles with rsp_ready held high.
- shift_* outputs keep their last value outside ISSUE; the Shifter is combinational, so only the ISSUE-cycle value matters.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1…
- rr_ptr only changes on a grant.
- Dropping req_valid while not granted is legal; the request is simply not taken.
- Simultaneous events:
  - rsp handshake and a new req_valid in the same cycle: the request is not accepted until the following IDLE cycle.
  - rst has priority over everything. Reset mid-ISSUE or mid-RESP discards the transaction, no response is produced, and all outputs return to reset values on the next edge.
- Width rules: shift_val is passed unmodified (0..15). Shift amounts ≥ DATA_W cannot occur.

Optional Feature:
- Macro SHIFT_ARB_ZERO_BYPASS_EN.
- Defined: a granted request with val == 0 and mode != 11 skips ISSUE. IDLE loads rsp_data directly from the operand and goes straight to RESP, so rsp_valid is high in N+1. The Shifter is not driven for that transaction.
- Undefined: every request takes the IDLE→ISSUE→RESP path, including val == 0.

Test Plan:
- Reset, then req0 only: data=0x8001, val=1, mode=00 → req_ready=01 at N; rsp_valid=01 at N+2; rsp_data=0x0002; rsp_err=0.
- Both valid every cycle, rsp_ready=11; req0 data=0x00F0 val=4 mode=01, req1 data=0x0001 val=1 mode=10 → grants alternate 0,1,0,1; rsp_data alternates 0x000F and 0x8000.
- req1 data=0x1234 val=3 mode=11 → rsp_valid=10 at N+2; rsp_data=0x1234; rsp_err=1; Shifter result ignored.
- Backpressure: req0 data=0xABCD val=8 mode=10 with rsp_ready=00 for 5 cycles → rsp_valid=01 and rsp_data=0xCDAB held stable; req_ready=00 throughout; IDLE one cycle after rsp_ready[0]=1.
- rst pulsed during RESP of req0 → next cycle rsp_valid=00, rsp_data=0, rr_ptr=0. A following simultaneous request grants requester 0.
- val=0: req0 data=0x5A5A, mode=00 → rsp_data=0x5A5A. rsp_valid at N+1 with SHIFT_ARB_ZERO_BYPASS_EN defined, at N+2 without.
